// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM bank and its read/write burst engines.
// Holds default geometry and the reader state encoding.
package sram_ctrl_pkg;

   localparam int default_data_width         = 8;
   localparam int default_address_depth_bits = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } reader_state_t;

endpackage

// File: rtl/sram_bank.sv
// Word-wide storage bank: synchronous write port, asynchronous read port.
// Writes land at the clock edge, so a same-edge read captures the old word.
module sram_bank
   import sram_ctrl_pkg::*;
#(
   parameter int data_width         = default_data_width,
   parameter int address_depth_bits = default_address_depth_bits
) (
   input  logic                          clk,
   input  logic                          write_enable,
   input  logic [address_depth_bits-1:0] write_address,
   input  logic [data_width-1:0]         write_data,
   input  logic [address_depth_bits-1:0] read_address,
   output logic [data_width-1:0]         read_data
);

   logic [data_width-1:0] mem [2**address_depth_bits];

   // NOTE: the storage array has no reset; clearing it would turn the RAM into
   // a flop bank, and every word is written before it is meaningfully read.
   always_ff @(posedge clk) begin
      if (write_enable) mem[write_address] <= write_data;
   end

   assign read_data = mem[read_address];

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read engine: walks an sram_bank read port one word per cycle and
// presents the words as a registered valid/ready stream with a last flag.
module sram_burst_reader
   import sram_ctrl_pkg::*;
#(
   parameter int data_width         = default_data_width,
   parameter int address_depth_bits = default_address_depth_bits
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [address_depth_bits-1:0] req_address,
   input  logic [address_depth_bits:0]   req_length,
   output logic [address_depth_bits-1:0] read_address,
   input  logic [data_width-1:0]         read_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [data_width-1:0]         out_data,
   output logic                          out_last,
   output logic                          busy
);

   localparam logic [address_depth_bits-1:0] addr_one   = address_depth_bits'(1);
   localparam logic [address_depth_bits:0]   length_one = (address_depth_bits + 1)'(1);

   reader_state_t                 state;
   reader_state_t                 state_next;
   logic [address_depth_bits-1:0] ptr;
   logic [address_depth_bits-1:0] remaining;  // words still to present after the current one
   logic                          load;
   logic                          advance;
   logic                          finish;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      req_ready    = 1'b0;
      busy         = 1'b0;
      read_address = ptr;
      load         = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      case (state)
         IDLE: begin
            req_ready    = 1'b1;
            read_address = req_address;
            // A zero-length request is consumed here without leaving IDLE.
            if (req_valid && (req_length != '0)) begin
               load       = 1'b1;
               state_next = STREAM;
            end
         end
         STREAM: begin
            busy = 1'b1;
            if (out_valid && out_ready) begin
               if (remaining == '0) begin
                  finish     = 1'b1;
                  state_next = IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         ptr       <= '0;
         remaining <= '0;
      end else if (load) begin
         out_data  <= read_data;
         out_valid <= 1'b1;
         out_last  <= (req_length == length_one);
         ptr       <= req_address + addr_one;
         remaining <= address_depth_bits'(req_length - length_one);
      end else if (advance) begin
         out_data  <= read_data;
         out_last  <= (remaining == addr_one);
         ptr       <= ptr + addr_one;
         remaining <= remaining - addr_one;
      end else if (finish) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Self-checking bench for sram_burst_reader attached to an sram_bank.
// Expected beats come from a plain array copy of the bank contents.
module tb_sram_burst_reader;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 2**AW;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_address;
   logic [AW:0]   req_length;
   logic [AW-1:0] read_address;
   logic [DW-1:0] read_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;

   logic [DW-1:0] mem_model [DEPTH];
   int            errors = 0;
   int            checks = 0;

   sram_burst_reader #(.data_width(DW), .address_depth_bits(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_address(req_address), .req_length(req_length),
      .read_address(read_address), .read_data(read_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   sram_bank #(.data_width(DW), .address_depth_bits(AW)) bank (
      .clk(clk), .write_enable(write_enable),
      .write_address(write_address), .write_data(write_data),
      .read_address(read_address), .read_data(read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Fill the whole bank; mode 0 = k+0x10, otherwise random.
   task automatic fill_bank(input int mode);
      for (int k = 0; k < DEPTH; k++) begin
         write_address = k[AW-1:0];
         write_data    = (mode == 0) ? DW'(k + 8'h10) : DW'($urandom);
         write_enable  = 1'b1;
         mem_model[k]  = write_data;
         @(negedge clk);
      end
      write_enable = 1'b0;
   endtask

   // Issue one request at a negedge and follow the burst to completion.
   // mode 0: out_ready always 1; 1: random; 2: pattern 1,0,0,1,0,1 then 1.
   // chain keeps req_valid high with the next request's fields after acceptance.
   task automatic do_burst(input logic [AW-1:0] addr, input int len, input int mode,
                           input bit chain, input logic [AW-1:0] next_addr,
                           input int next_len, input string name);
      logic [DW-1:0] q[$];
      bit            pat [0:5];
      bit            rdy;
      int            cycles;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      req_valid   = 1'b1;
      req_address = addr;
      req_length  = len[AW:0];
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL %s req_ready before accept: got %b expected 1", name, req_ready);
      end
      checks++;
      if (read_address !== addr) begin
         errors++; $display("FAIL %s idle read_address: got %0d expected %0d", name, read_address, addr);
      end
      @(negedge clk);
      if (chain) begin
         req_address = next_addr;
         req_length  = next_len[AW:0];
      end else begin
         req_valid = 1'b0;
      end
      for (int i = 0; i < len; i++) q.push_back(mem_model[(int'(addr) + i) % DEPTH]);
      if (len == 0) begin
         checks++;
         if (out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s zero length: got valid=%b ready=%b busy=%b expected 0 1 0",
                     name, out_valid, req_ready, busy);
         end
         return;
      end
      cycles = 0;
      while (q.size() > 0) begin
         if (cycles >= 200) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d beats left expected 0", name, q.size());
            break;
         end
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s valid/busy in burst: got %b/%b expected 1/1", name, out_valid, busy);
         end
         checks++;
         if (out_data !== q[0]) begin
            errors++; $display("FAIL %s out_data: got %0h expected %0h", name, out_data, q[0]);
         end
         checks++;
         if (out_last !== (q.size() == 1)) begin
            errors++;
            $display("FAIL %s out_last: got %b expected %b", name, out_last, q.size() == 1);
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (cycles < 6) ? pat[cycles] : 1'b1;
         endcase
         out_ready = rdy;
         if (rdy) void'(q.pop_front());
         cycles++;
         @(negedge clk);
      end
      if (mode == 0) begin
         checks++;
         if (cycles !== len) begin
            errors++; $display("FAIL %s burst cycles: got %0d expected %0d", name, cycles, len);
         end
      end
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after burst: got valid=%b last=%b busy=%b ready=%b expected 0 0 0 1",
                  name, out_valid, out_last, busy, req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_address = 5'd7; req_length = '0;
      out_ready = 1'b0; write_enable = 1'b0; write_address = '0; write_data = '0;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset outputs: got valid=%b last=%b data=%0h expected 0 0 0",
                  out_valid, out_last, out_data);
      end
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || read_address !== 5'd7) begin
         errors++;
         $display("FAIL reset control: got ready=%b busy=%b raddr=%0d expected 1 0 7",
                  req_ready, busy, read_address);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL after release: got ready=%b valid=%b expected 1 0", req_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      do_burst(5'd3, 4, 0, 1'b0, '0, 0, "basic");
   endtask

   task automatic test_wrap();
      do_burst(5'd30, 4, 0, 1'b0, '0, 0, "wrap");
      do_burst(5'd0, 32, 0, 1'b0, '0, 0, "full_depth");
   endtask

   task automatic test_backpressure();
      do_burst(5'd12, 3, 2, 1'b0, '0, 0, "backpressure");
   endtask

   task automatic test_length_edges();
      do_burst(5'd9, 1, 0, 1'b0, '0, 0, "len_one");
      do_burst(5'd9, 0, 0, 1'b0, '0, 0, "len_zero");
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL len_zero later: got valid=%b ready=%b expected 0 1", out_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      do_burst(5'd5, 3, 0, 1'b1, 5'd20, 2, "b2b_first");
      do_burst(5'd20, 2, 0, 1'b0, '0, 0, "b2b_second");
   endtask

   task automatic test_reset_mid_burst();
      req_valid = 1'b1; req_address = 5'd8; req_length = 6'd5; out_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== mem_model[8 + i]) begin
            errors++;
            $display("FAIL mid_reset beat %0d: got valid=%b data=%0h expected 1 %0h",
                     i, out_valid, out_data, mem_model[8 + i]);
         end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset async: got valid=%b last=%b busy=%b ready=%b expected 0 0 0 1",
                  out_valid, out_last, busy, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_burst(5'd20, 3, 0, 1'b0, '0, 0, "after_reset");
   endtask

   task automatic test_random();
      fill_bank(1);
      for (int n = 0; n < 8; n++) begin
         do_burst(AW'($urandom), $urandom_range(0, DEPTH), 1, 1'b0, '0, 0, "random");
      end
      do_burst(5'd17, 32, 1, 1'b0, '0, 0, "random_full");
   endtask

   initial begin
      test_reset();
      fill_bank(0);
      test_basic();
      test_wrap();
      test_backpressure();
      test_length_edges();
      test_back_to_back();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-side burst engine for an `sram_bank` instance. It accepts a burst request (start address and length) and walks the bank's asynchronous read port one word per cycle. It presents the words as a registered valid/ready stream with a last flag. It sits between the bank's read port and any downstream consumer (DMA, UART TX, packet framer), mirroring the write path that fills the bank.

## Interface
- `data_width`, 8, word width; must match the attached `sram_bank`.
- `address_depth_bits`, 5, bank address width; depth = 2**`address_depth_bits`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  burst request present.
- `req_ready`  out  1  engine can accept a request.
- `req_address`  in  `address_depth_bits`  first word address.
- `req_length`  in  `address_depth_bits`+1  word count, 0..2**`address_depth_bits`.
- `read_address`  out  `address_depth_bits`  to `sram_bank.read_address`.
- `read_data`  in  `data_width`  from `sram_bank.read_data` (combinational).
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts word.
- `out_data`  out  `data_width`  stream word, registered.
- `out_last`  out  1  final word of burst, qualified by `out_valid`.
- `busy`  out  1  burst in progress (state STREAM).

## Operation
- States: IDLE, STREAM.
- IDLE:
  - `req_ready`=1, `busy`=0.
  - `read_address` = `req_address`, combinational pass-through.
  - Acceptance when `req_valid`&&`req_ready`.
- Accept with `req_length`≥1:
  - `out_data`<=`read_data`, `out_valid`<=1.
  - `out_last`<=(`req_length`==1).
  - ptr<=`req_address`+1, remaining<=`req_length`-1.
  - Transition to STREAM.
- Accept with `req_length`==0: the request is consumed, no beats are produced, and the engine stays in IDLE.
- STREAM:
  - `req_ready`=0, `busy`=1, `read_address`=ptr.
  - On `out_valid`&&`out_ready` with remaining==0: `out_valid`<=0, `out_last`<=0, go to IDLE.
  - On `out_valid`&&`out_ready` with remaining>0:
    - `out_data`<=`read_data`, ptr<=ptr+1, remaining<=remaining-1.
    - `out_last`<=(remaining==1).
  - Without handshake: `out_data`, `out_last`, ptr and remaining hold.
- Address arithmetic is modulo 2**`address_depth_bits`. A burst crossing the top address wraps to 0. A full-depth burst (length 2**N) reads every word exactly once.
- remaining is `address_depth_bits` bits wide.

## Timing
- Reset (async assert, sync release):
  - State IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, ptr=0, remaining=0.
  - Hence `req_ready`=1, `busy`=0, `read_address`=`req_address`.
- Latency: request accepted at edge N, so the first word is valid after edge N (cycle N+1).
- Throughput: with `out_ready` held high, one word per cycle. A length-L burst occupies cycles N+1..N+L.
- Back-to-back bursts: the engine returns to IDLE the cycle after the last handshake. The next request is accepted there, so there is exactly one idle cycle between bursts.
- AXI-style stream rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are stable.
  - `out_valid` never drops without a handshake.
- Write collision: the bank writes synchronously. If the writer targets the address currently on `read_address` in the capture cycle, the reader captures the OLD word (read-before-write). Software must not overwrite words inside an active burst.
- `req_*` inputs are ignored in STREAM.
- Reset mid-burst aborts immediately; no `out_last` is produced.

## Structure
- Shared package (`sram_ctrl_pkg`):
  - State encoding constants IDLE=1'b0, STREAM=1'b1.
  - Default `data_width`/`address_depth_bits` constants, shared with `sram_bank` and the write engine.
- Single module, no sub-module. The datapath is one address counter and one down-counter plus an output register.
- The bench instantiates `sram_bank` alongside it.

## Test plan
- Preload bank[k]=k+8'h10; request addr=3, len=4, `out_ready`=1 -> beats 13,14,15,16 on consecutive cycles starting one cycle after accept; `out_last` only on 16; `busy` 4 cycles.
- Wrap: addr=30, len=4, depth 32 -> beats bank[30],[31],[0],[1]; full-depth len=32 from addr=0 -> all 32 words, last on bank[31].
- Backpressure: len=3, `out_ready` toggled 1,0,0,1,0,1 -> `out_data` stable while stalled, three beats total, no duplication or skip.
- Length edge cases: len=1 -> single beat with `out_last`=1; len=0 -> `req_ready` stays 1, `out_valid` never asserts.
- Back-to-back requests held valid -> second burst's first beat appears exactly one idle cycle after first burst's last handshake.
- Assert `rst_n`=0 mid-burst (after 2 of 5 beats) -> `out_valid`/`out_last`/`busy` 0 asynchronously; after release, `req_ready`=1 and a new burst runs correctly.
